// File: rtl/stage_buffer_pkg.sv
// buffer_pkg: shared perf-counter type, saturation limit and saturating add
package buffer_pkg;

    typedef logic [31:0] perf_cnt_t;

    localparam perf_cnt_t PERF_CNT_MAX = 32'hFFFF_FFFF;

    function automatic perf_cnt_t sat_inc(input perf_cnt_t cnt, input perf_cnt_t amount);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {1'b0, amount};
        return sum[32] ? PERF_CNT_MAX : sum[31:0];
    endfunction

endpackage

// File: rtl/stage_buffer_fifo_ptr.sv
// fifo_ptr: read/write pointers and occupancy for a power-of-two FIFO
module fifo_ptr #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH)-1:0]   wptr,
    output logic [$clog2(DEPTH)-1:0]   rptr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // pointers wrap naturally; flush clears everything at the next edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(push);
            rptr  <= rptr + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/stage_buffer.sv
// stage_buffer: elastic FIFO stage register with flush; optional perf counters via STAGE_BUFFER_PERF_EN
module stage_buffer
    import buffer_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef STAGE_BUFFER_PERF_EN
    ,
    output perf_cnt_t                  stall_cycles,
    output perf_cnt_t                  flush_drops
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             push;
    logic             pop;

    assign in_ready  = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign out_data  = mem[rptr];
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    fifo_ptr #(.DEPTH(DEPTH)) ptrs (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wptr  (wptr),
        .rptr  (rptr),
        .count (count)
    );

    // payload storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end

`ifdef STAGE_BUFFER_PERF_EN
    // saturating stall and flush-drop counters; a head popped during flush is not a drop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_drops  <= '0;
        end else begin
            if (out_valid && !out_ready) stall_cycles <= sat_inc(stall_cycles, 32'd1);
            if (flush) flush_drops <= sat_inc(flush_drops, perf_cnt_t'(count) - perf_cnt_t'(pop));
        end
    end
`endif

endmodule
